// File: rtl/multi_acc_alu_pkg.sv
// Shared types for the multi-accumulator ALU: op codes, flag bit positions, FSM states.
package multi_acc_alu_pkg;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_ADC  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_XOR  = 3'd6,
        OP_MUL  = 3'd7
    } op_e;

    localparam int FLAG_W = 4;
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/multi_acc_alu_if.sv
// Request/response bundle between the I/O pin logic (master) and the accumulator ALU (slave).
interface multi_acc_alu_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_ACC = 4
);
    import multi_acc_alu_pkg::*;

    localparam int SEL_W = $clog2(NUM_ACC);

    logic               in_valid;
    logic               in_ready;
    op_e                op;
    logic [SEL_W-1:0]   acc_sel;
    logic [WIDTH-1:0]   operand;
    logic               out_valid;
    logic [WIDTH-1:0]   result;
    logic [FLAG_W-1:0]  flags;

    modport master (
        output in_valid, op, acc_sel, operand,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, acc_sel, operand,
        output in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/multi_acc_alu_mul.sv
// Sequential shift-add multiplier, one partial product per cycle.
// Latency: WIDTH cycles after start; done/prod are valid combinationally during the last step.
// Backpressure: none; a new start is only issued by the owner once the previous run is done.
module multi_acc_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] sum_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic [2*WIDTH-1:0] step_sum;

    // prod exposes the final step's sum so the owner can write back in the same cycle
    assign step_sum = sum_q + (mplier_q[0] ? mcand_q : '0);
    assign done     = busy_q && (cnt_q == CNT_W'(WIDTH-1));
    assign prod     = step_sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            sum_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            sum_q    <= '0;
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            sum_q    <= step_sum;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_acc_alu.sv
// Bank of NUM_ACC accumulators with a shared flag register and an 8-op ALU.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL.
// Backpressure: in_ready drops for WIDTH cycles while a MUL runs and while rst_n is low.
module multi_acc_alu
    import multi_acc_alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_ACC = 4,
    parameter int SEL_W   = $clog2(NUM_ACC)
) (
    input  logic               clk,
    input  logic               rst_n,
    multi_acc_alu_if.slave     bus
);
    localparam int MSB = WIDTH - 1;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    acc_q [NUM_ACC];
    logic [FLAG_W-1:0]   flags_q, flags_d;
    logic [WIDTH-1:0]    result_q;
    logic                out_valid_q;
    logic [SEL_W-1:0]    sel_q;

    logic                accept, mul_start, mul_done, wb;
    logic [2*WIDTH-1:0]  mul_prod;
    logic [SEL_W-1:0]    cur_sel;
    op_e                 cur_op;
    logic [WIDTH-1:0]    a_cur, b_cur, alu_res;
    logic [WIDTH:0]      wide;
    logic                cin, cf, vf;

    assign bus.in_ready  = (state_q == ST_IDLE) && rst_n;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

    // While a MUL runs the bus fields are don't-care; the latched target drives the datapath
    assign cur_sel = (state_q == ST_MUL) ? sel_q : bus.acc_sel;
    assign cur_op  = (state_q == ST_MUL) ? OP_MUL : bus.op;
    assign a_cur   = acc_q[cur_sel];
    assign b_cur   = bus.operand;
    assign cin     = (cur_op == OP_ADC) && flags_q[FLAG_C];

    always_comb begin
        state_d   = state_q;
        wb        = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
                    end else begin
                        wb = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    wb      = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wide    = '0;
        alu_res = '0;
        cf      = 1'b0;
        vf      = 1'b0;
        case (cur_op)
            OP_LOAD: alu_res = b_cur;
            OP_ADD, OP_ADC: begin
                wide    = {1'b0, a_cur} + {1'b0, b_cur} + {{WIDTH{1'b0}}, cin};
                alu_res = wide[MSB:0];
                cf      = wide[WIDTH];
                vf      = (a_cur[MSB] == b_cur[MSB]) && (alu_res[MSB] != a_cur[MSB]);
            end
            OP_SUB: begin
                wide    = {1'b0, a_cur} - {1'b0, b_cur};
                alu_res = wide[MSB:0];
                cf      = wide[WIDTH];
                vf      = (a_cur[MSB] != b_cur[MSB]) && (alu_res[MSB] != a_cur[MSB]);
            end
            OP_AND: alu_res = a_cur & b_cur;
            OP_OR:  alu_res = a_cur | b_cur;
            OP_XOR: alu_res = a_cur ^ b_cur;
            OP_MUL: begin
                alu_res = mul_prod[MSB:0];
                cf      = |mul_prod[2*WIDTH-1:WIDTH];
            end
            default: alu_res = '0;
        endcase
        flags_d         = '0;
        flags_d[FLAG_C] = cf;
        flags_d[FLAG_Z] = (alu_res == '0);
        flags_d[FLAG_V] = vf;
        flags_d[FLAG_N] = alu_res[MSB];
    end

    multi_acc_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (a_cur),
        .b     (b_cur),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < NUM_ACC; i++) begin
                acc_q[i] <= '0;
            end
            flags_q     <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= wb;
            if (mul_start) begin
                sel_q <= bus.acc_sel;
            end
            if (wb) begin
                acc_q[cur_sel] <= alu_res;
                result_q       <= alu_res;
                flags_q        <= flags_d;
            end
        end
    end

endmodule

// File: tb/tb_multi_acc_alu.sv
// Randomized and directed stimulus for multi_acc_alu checked against an integer reference model.
module tb_multi_acc_alu;
    import multi_acc_alu_pkg::*;

    typedef struct {
        int op;
        int sel;
        int val;
        bit has_exp;
        int exp_res;
        int exp_flg;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_acc_alu_if #(.WIDTH(8), .NUM_ACC(4)) bus ();

    multi_acc_alu #(.WIDTH(8), .NUM_ACC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    req_t q[$];
    int   acc_m [4];
    int   cf_m;
    bit   pend_vld;
    bit   pend_has;
    int   pend_cnt, busy_cnt;
    int   pend_res, pend_flg, pend_sres, pend_sflg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Returns {flags[3:0] = {N,V,Z,C}, result[7:0]} computed with plain integer arithmetic
    function automatic logic [11:0] ref_op(input int op, input int a, input int b, input int cf);
        int r, c, v, sa, sb, sr;
        logic [7:0] res;
        logic n, z;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        c = 0; v = 0; r = 0;
        case (op)
            0: r = b;
            1: begin r = a + b;      c = (r > 255); sr = sa + sb;      v = (sr > 127 || sr < -128); end
            2: begin r = a - b;      c = (a < b);   sr = sa - sb;      v = (sr > 127 || sr < -128); end
            3: begin r = a + b + cf; c = (r > 255); sr = sa + sb + cf; v = (sr > 127 || sr < -128); end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            default: begin r = a * b; c = (r > 255); end
        endcase
        r   = r & 255;
        res = r[7:0];
        n   = (r > 127);
        z   = (r == 0);
        return {n, v[0], z, c[0], res};
    endfunction

    task automatic push(input int op, input int sel, input int val, input bit has,
                        input int er, input int ef);
        req_t r;
        r.op = op; r.sel = sel; r.val = val; r.has_exp = has; r.exp_res = er; r.exp_flg = ef;
        q.push_back(r);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) acc_m[i] = 0;
        cf_m = 0; pend_vld = 0; pend_cnt = 0; busy_cnt = 0;
    endtask

    // Drains the request queue; pct is the chance a fresh request is presented in a given cycle
    task automatic run_queue(input int pct);
        int guard;
        int limit;
        bit holding;
        bit present;
        bit exp_ov;
        req_t r;
        logic [11:0] m;
        guard = 0;
        holding = 0;
        limit = 20 * q.size() + 50;
        forever begin
            @(negedge clk);
            if (pend_cnt > 0) pend_cnt--;
            if (busy_cnt > 0) busy_cnt--;
            exp_ov = pend_vld && (pend_cnt == 0);
            chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
            if (exp_ov) begin
                chk("result", {24'd0, bus.result}, pend_res);
                chk("flags", {28'd0, bus.flags}, pend_flg);
                if (pend_has) begin
                    chk("result_const", {24'd0, bus.result}, pend_sres);
                    chk("flags_const", {28'd0, bus.flags}, pend_sflg);
                end
                pend_vld = 0;
            end
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, busy_cnt == 0});
            if (q.size() == 0 && !pend_vld) begin
                bus.in_valid = 1'b0;
                break;
            end
            guard++;
            if (guard > limit) begin
                chk("queue_timeout", guard, limit);
                bus.in_valid = 1'b0;
                break;
            end
            present = 0;
            if (q.size() > 0) present = holding || ($urandom_range(99) < pct);
            if (present) begin
                r = q[0];
                bus.in_valid = 1'b1;
                bus.op       = op_e'(3'(r.op));
                bus.acc_sel  = 2'(r.sel);
                bus.operand  = 8'(r.val);
                holding = 1;
                if (busy_cnt == 0) begin
                    m = ref_op(r.op, acc_m[r.sel], r.val, cf_m);
                    acc_m[r.sel] = int'(m[7:0]);
                    cf_m      = int'(m[8]);
                    pend_vld  = 1;
                    pend_res  = int'(m[7:0]);
                    pend_flg  = int'(m[11:8]);
                    pend_has  = r.has_exp;
                    pend_sres = r.exp_res;
                    pend_sflg = r.exp_flg;
                    pend_cnt  = (r.op == 7) ? 9 : 1;
                    busy_cnt  = (r.op == 7) ? 9 : 0;
                    holding   = 0;
                    void'(q.pop_front());
                end
            end else begin
                bus.in_valid = 1'b0;
                bus.op       = op_e'(3'($urandom_range(7)));
                bus.acc_sel  = 2'($urandom_range(3));
                bus.operand  = 8'($urandom_range(255));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.op       = OP_LOAD;
        bus.acc_sel  = '0;
        bus.operand  = '0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("in_ready_in_reset", {31'd0, bus.in_ready}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_result", {24'd0, bus.result}, 0);
        chk("rst_flags", {28'd0, bus.flags}, 0);

        // Directed: carry/overflow, ADC chain, borrow, multiply, back-to-back, bank isolation
        push(0, 0, 'h7F, 1, 'h7F, 4'b0000);
        push(1, 0, 'h01, 1, 'h80, 4'b1100);
        push(0, 1, 'hFF, 1, 'hFF, 4'b1000);
        push(1, 1, 'h01, 1, 'h00, 4'b0011);
        push(3, 1, 'h00, 1, 'h01, 4'b0000);
        push(0, 2, 'h05, 1, 'h05, 4'b0000);
        push(2, 2, 'h07, 1, 'hFE, 4'b1001);
        push(0, 3, 'h12, 1, 'h12, 4'b0000);
        push(7, 3, 'h34, 1, 'hA8, 4'b1001);
        push(0, 0, 'h00, 1, 'h00, 4'b0010);
        for (int i = 1; i <= 4; i++) push(1, 0, 'h03, 1, 3 * i, 4'b0000);
        push(5, 1, 'h00, 1, 'h01, 4'b0000);
        push(5, 2, 'h00, 1, 'hFE, 4'b1000);
        push(5, 3, 'h00, 1, 'hA8, 4'b1000);
        run_queue(100);

        for (int i = 0; i < 150; i++)
            push($urandom_range(7), $urandom_range(3), $urandom_range(255), 0, 0, 0);
        run_queue(70);

        // Reset arriving in the middle of a MUL
        @(negedge clk);
        chk("mid_mul_ready_k", {31'd0, bus.in_ready}, 1);
        bus.in_valid = 1'b1;
        bus.op       = OP_MUL;
        bus.acc_sel  = 2'd2;
        bus.operand  = 8'h34;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("mid_mul_busy", {31'd0, bus.in_ready}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_mul_ready_rst", {31'd0, bus.in_ready}, 0);
        chk("mid_mul_ov_rst", {31'd0, bus.out_valid}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, bus.in_ready}, 1);
        chk("post_rst_ov", {31'd0, bus.out_valid}, 0);
        chk("post_rst_result", {24'd0, bus.result}, 0);
        chk("post_rst_flags", {28'd0, bus.flags}, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {31'd0, bus.out_valid}, 0);
        end
        model_reset();
        for (int i = 0; i < 4; i++) push(5, i, 'h00, 1, 'h00, 4'b0010);
        run_queue(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_acc_alu.md
# multi_acc_alu

Parametrised accumulator/ALU datapath, successor to the single 8-bit adder-accumulator. It holds NUM_ACC accumulators of WIDTH bits and one shared flag register. It executes one operation per valid/ready transaction: eight ops, including add-with-carry and a multi-cycle shift-add multiply. It sits between the tile's I/O pin logic and the accumulator bank, replacing the fixed add/sub ALU and single accumulator register.

## Interface
Parameters:
- WIDTH, 8, datapath and accumulator width (≥4)
- NUM_ACC, 4, number of accumulators (power of 2, ≥2)
- SEL_W, $clog2(NUM_ACC), derived; not to be overridden

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- op  in  3  operation code
- acc_sel  in  SEL_W  target accumulator
- operand  in  WIDTH  second operand
- out_valid  out  1  one-cycle pulse: result/flags updated
- result  out  WIDTH  new value of the selected accumulator
- flags  out  4  {NF, VF, ZF, CF}

## Operation
- Accept when in_valid && in_ready. op, acc_sel and operand are sampled only at accept.
- A = acc[acc_sel]; the result is written back to acc[acc_sel], result, and flags.
- Op codes:
  - 000 LOAD: operand
  - 001 ADD: A+operand
  - 010 SUB: A−operand
  - 011 ADC: A+operand+CF, using CF from the flag register
  - 100 AND
  - 101 OR
  - 110 XOR
  - 111 MUL: low WIDTH bits of A×operand, unsigned
- Arithmetic is computed at WIDTH+1 bits. The result is truncated to WIDTH bits; wrap-around is normal.
- Flags are updated by every op:
  - ZF = (result==0)
  - NF = result[WIDTH-1]
  - CF:
    - ADD/ADC: carry out
    - SUB: borrow (A<operand unsigned)
    - MUL: upper WIDTH bits of the product are non-zero
    - LOAD/logic: 0
  - VF:
    - ADD/ADC/SUB: two's-complement overflow
    - otherwise 0
- Unselected accumulators are never modified.
- result and flags hold their value until the next completion.
- FSM states:
  - IDLE: in_ready=1. Non-MUL accept stays in IDLE; MUL accept goes to MUL.
  - MUL: in_ready=0. Runs a WIDTH-step shift-add; after step WIDTH it writes back and returns to IDLE.
- Requests presented while in_ready=0 are ignored. The requester must hold them until accepted.

## Timing
- Reset (rst_n sampled low at an edge):
  - all accumulators 0, flags 0, result 0
  - out_valid 0, state IDLE
  - in_ready forced 0 while rst_n is low
  - in_ready=1 in the first cycle after release
- Non-MUL accept in cycle k: write-back at the end of cycle k; out_valid=1 in cycle k+1. Latency 1, throughput 1 op/cycle.
- Back-to-back ops on the same accumulator see the previous result; no hazard stall. ADC sees CF from the immediately preceding op.
- MUL accept in cycle k:
  - in_ready=0 in cycles k+1..k+WIDTH
  - write-back at the end of cycle k+WIDTH
  - out_valid=1 and in_ready=1 in cycle k+WIDTH+1
  - the next accept is possible in cycle k+WIDTH+1
- Reset mid-MUL aborts it: no out_valid, no write-back beyond the reset values.
- out_valid is never high for two consecutive cycles from one request. Consecutive pulses occur only for consecutive accepts.

## Structure
- Package multi_acc_alu_pkg holds:
  - op enum (OP_LOAD…OP_MUL)
  - flag bit indices (FLAG_C=0, FLAG_Z=1, FLAG_V=2, FLAG_N=3)
  - FSM state enum (ST_IDLE, ST_MUL)
- Sub-module multi_acc_alu_mul: sequential shift-add multiplier.
  - Ports: clk, rst_n, start, a, b, done, prod (2·WIDTH bits).
  - done pulses in the cycle its WIDTH-th step completes.
- Top level holds the accumulator array, flag register, single-cycle combinational ALU, FSM and handshake.

## Test plan
All cases at WIDTH=8, NUM_ACC=4.
- Carry/overflow: reset; LOAD acc0=0x7F; ADD 0x01 → result 0x80, NF=1 VF=1 ZF=0 CF=0, out_valid exactly one cycle after accept.
- ADC chain: LOAD acc1=0xFF; ADD 0x01 → 0x00, ZF=1 CF=1; then ADC 0x00 → 0x01, CF=0 ZF=0.
- Borrow: LOAD acc2=0x05; SUB 0x07 → 0xFE, CF=1 NF=1 VF=0.
- Multiply: LOAD acc3=0x12; MUL 0x34 → result 0xA8, CF=1.
  - in_ready low for 8 cycles; out_valid 9 cycles after accept.
  - A request held during busy is accepted only in the out_valid cycle.
- Back-to-back: ADD 0x03 to acc0 (from 0) on 4 consecutive cycles → results 0x03, 0x06, 0x09, 0x0C; out_valid high 4 cycles; acc1–acc3 unchanged.
- Reset mid-MUL: assert rst_n=0 during cycle k+4 of a MUL → no out_valid; all accumulators, result and flags 0; in_ready=1 in the first cycle after release.
